asel_operand_mux: RTL and testbench



---
 rtl/rv32i_pkg.sv | 13 +
 rtl/asel_operand_mux_if.sv | 30 +++
 rtl/asel_mux2.sv | 21 ++
 rtl/asel_operand_mux.sv | 45 ++++
 tb/tb_asel_operand_mux.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath definitions.
//   XLEN   : architectural register / datapath width.
//   asel_e : operand-A source select, also used by the control decoder.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    ASEL_RS1 = 1'b0,
    ASEL_PC  = 1'b1
  } asel_e;

endpackage

// File: rtl/asel_operand_mux_if.sv
// Operand-A select bus.
//   data1     : rs1 read data from the register file
//   pc_out    : current PC
//   ASel_pin  : operand-A select (0 = data1, 1 = pc_out)
//   cap_en    : capture enable for the registered copy
//   Asel_op   : combinational selected operand A
//   Asel_op_q : registered copy of Asel_op
// master drives the inputs and observes the outputs; slave is the mux.
interface asel_operand_mux_if #(
  parameter int unsigned XLEN = 32
);

  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] pc_out;
  logic            ASel_pin;
  logic            cap_en;
  logic [XLEN-1:0] Asel_op;
  logic [XLEN-1:0] Asel_op_q;

  modport master (
    output data1, pc_out, ASel_pin, cap_en,
    input  Asel_op, Asel_op_q
  );

  modport slave (
    input  data1, pc_out, ASel_pin, cap_en,
    output Asel_op, Asel_op_q
  );

endinterface

// File: rtl/asel_mux2.sv
// Generic 2:1 multiplexer.
//   in0   : selected when sel is not 1 (including X/Z)
//   in1   : selected when sel == 1
//   sel   : select
//   out   : selected value
module asel_mux2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // Equality test so an undriven select resolves to in0 rather than X.
  always_comb begin
    if (sel == 1'b1) out = in1;
    else             out = in0;
  end

endmodule

// File: rtl/asel_operand_mux.sv
// Operand-A source select for the RV32I ALU.
//   clk   : design clock, rising edge
//   rst_n : asynchronous active-low reset (clears Asel_op_q only)
//   bus   : slave side of asel_operand_mux_if
//           Asel_op   = ASel_pin ? pc_out : data1 (combinational)
//           Asel_op_q = Asel_op captured on clk when cap_en, RESET_VAL on reset
module asel_operand_mux
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN      = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  asel_operand_mux_if.slave        bus
);

  asel_e           asel;
  logic [XLEN-1:0] op;
  logic [XLEN-1:0] op_q;

  // Anything other than a driven 1 maps to the rs1 source.
  always_comb begin
    if (bus.ASel_pin == 1'b1) asel = ASEL_PC;
    else                      asel = ASEL_RS1;
  end

  asel_mux2 #(
    .WIDTH (XLEN)
  ) u_mux (
    .in0 (bus.data1),
    .in1 (bus.pc_out),
    .sel (asel == ASEL_PC),
    .out (op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          op_q <= RESET_VAL;
    else if (bus.cap_en) op_q <= op;
  end

  assign bus.Asel_op   = op;
  assign bus.Asel_op_q = op_q;

endmodule

// File: tb/tb_asel_operand_mux.sv
// Bench for asel_operand_mux: stimulus pushes expected values into a
// scoreboard queue and fires a sample event; a monitor pops and compares.
module tb_asel_operand_mux;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  asel_operand_mux_if #(.XLEN(XLEN)) bus ();

  asel_operand_mux #(
    .XLEN      (XLEN),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    bit          is_q;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  event chk_ev;

  task automatic exp_op(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n; e.is_q = 1'b0; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic exp_q(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n; e.is_q = 1'b1; e.exp = v;
    sb.push_back(e);
  endtask

  // Let combinational paths settle, then hand the queue to the monitor.
  task automatic sample();
    #1;
    -> chk_ev;
    #1;
  endtask

  // Monitor
  initial begin
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = sb.pop_front();
        act = e.is_q ? bus.Asel_op_q : bus.Asel_op;
        tests++;
        if (act !== e.exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    rst_n      = 1'b0;
    bus.data1  = 32'h0000_5555;
    bus.pc_out = 32'h0000_1111;
    bus.cap_en = 1'b1;
    // ASel_pin intentionally left undriven here.
    sample();
    exp_op("undriven_sel", 32'h0000_5555);
    exp_q ("reset_q",      32'h0000_0000);
    sample();

    bus.ASel_pin = 1'b0;
    exp_op("sel0_data1", 32'h0000_5555);
    sample();
    bus.ASel_pin = 1'b1;
    exp_op("sel1_pc", 32'h0000_1111);
    exp_q ("q_in_reset", 32'h0000_0000);
    sample();
    bus.ASel_pin = 1'b0;
    exp_op("sel0_back", 32'h0000_5555);
    sample();

    // Release reset away from the edge, select PC.
    @(negedge clk);
    rst_n        = 1'b1;
    bus.ASel_pin = 1'b1;
    sample();
    exp_q("q_before_first_edge", 32'h0000_0000);
    sample();
    @(posedge clk);
    sample();
    exp_q("q_first_capture", 32'h0000_1111);
    sample();

    // Hold with cap_en low.
    @(negedge clk);
    bus.cap_en   = 1'b0;
    bus.data1    = 32'hDEAD_BEEF;
    bus.ASel_pin = 1'b0;
    sample();
    exp_op("op_deadbeef", 32'hDEAD_BEEF);
    exp_q ("q_hold_pre", 32'h0000_1111);
    sample();
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk);
      sample();
      exp_q($sformatf("q_hold_edge%0d", i), 32'h0000_1111);
      sample();
    end
    @(negedge clk);
    bus.cap_en = 1'b1;
    @(posedge clk);
    sample();
    exp_q("q_capture_resume", 32'hDEAD_BEEF);
    sample();

    // Full-width value through the PC leg.
    @(negedge clk);
    bus.pc_out   = 32'hFFFF_FFFF;
    bus.ASel_pin = 1'b1;
    sample();
    exp_op("op_all_ones", 32'hFFFF_FFFF);
    sample();
    @(posedge clk);
    sample();
    exp_q("q_all_ones", 32'hFFFF_FFFF);
    sample();

    // Back to 0000_1111 in q, then reset mid-cycle.
    @(negedge clk);
    bus.pc_out = 32'h0000_1111;
    @(posedge clk);
    sample();
    exp_q("q_pre_reset", 32'h0000_1111);
    sample();
    rst_n = 1'b0;
    sample();
    exp_q ("q_async_reset", 32'h0000_0000);
    exp_op("op_during_reset", 32'h0000_1111);
    sample();
    @(posedge clk);
    sample();
    exp_q("q_held_in_reset", 32'h0000_0000);
    sample();

    // Release and capture again on the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    sample();
    exp_q("q_capture_after_release", 32'h0000_1111);
    sample();

    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
